csr_machine: RTL and testbench

Parametrised machine-mode CSR unit that generalises the single-hart CSR file. It adds configurable XLEN and hardware performance counters, full trap entry/return (exceptions and MEI/MSI/MTI interrupts with fixed priority), vectored mtvec, mtval, mcountinhibit, and internal illegal-CSR detection. It sits in the execute/commit stage. It consumes retiring-instruction information and produces read data plus a same-cycle PC redirect.

---
 rtl/csr_machine_pkg.sv | 50 +++++
 rtl/csr_machine_if.sv | 31 +++
 rtl/csr_machine_counter.sv | 37 +++
 rtl/csr_machine.sv | 249 ++++++++++++++++++++++++
 tb/tb_csr_machine.sv | 231 +++++++++++++++++++++++
 5 files changed

// File: rtl/csr_machine_pkg.sv
// Shared definitions for csr_machine: CSR addresses, trap cause codes,
// mstatus/mip bit positions, csr_op encodings and small decode helpers.
package csr_machine_pkg;

    typedef enum logic [1:0] {
        CSR_OP_NONE = 2'b00,
        CSR_OP_RW   = 2'b01,
        CSR_OP_RS   = 2'b10,
        CSR_OP_RC   = 2'b11
    } csr_op_e;

    localparam logic [11:0] CSR_MSTATUS       = 12'h300;
    localparam logic [11:0] CSR_MISA          = 12'h301;
    localparam logic [11:0] CSR_MIE           = 12'h304;
    localparam logic [11:0] CSR_MTVEC         = 12'h305;
    localparam logic [11:0] CSR_MCOUNTINHIBIT = 12'h320;
    localparam logic [11:0] CSR_MSCRATCH      = 12'h340;
    localparam logic [11:0] CSR_MEPC          = 12'h341;
    localparam logic [11:0] CSR_MCAUSE        = 12'h342;
    localparam logic [11:0] CSR_MTVAL         = 12'h343;
    localparam logic [11:0] CSR_MIP           = 12'h344;
    localparam logic [11:0] CSR_MCYCLE        = 12'hB00;
    localparam logic [11:0] CSR_MINSTRET      = 12'hB02;
    localparam logic [11:0] CSR_MHPMCOUNTER3  = 12'hB03;
    localparam logic [11:0] CSR_MVENDORID     = 12'hF11;
    localparam logic [11:0] CSR_MARCHID       = 12'hF12;
    localparam logic [11:0] CSR_MIMPID        = 12'hF13;
    localparam logic [11:0] CSR_MHARTID       = 12'hF14;

    localparam logic [3:0] CAUSE_ILLEGAL_INST = 4'd2;
    localparam logic [3:0] IRQ_CODE_MSI       = 4'd3;
    localparam logic [3:0] IRQ_CODE_MTI       = 4'd7;
    localparam logic [3:0] IRQ_CODE_MEI       = 4'd11;

    localparam int unsigned MSTATUS_MIE  = 3;
    localparam int unsigned MSTATUS_MPIE = 7;
    localparam int unsigned MIP_MSIP     = 3;
    localparam int unsigned MIP_MTIP     = 7;
    localparam int unsigned MIP_MEIP     = 11;

    function automatic logic csr_is_read_only(input logic [11:0] idx);
        return idx[11:10] == 2'b11;
    endfunction

    // RS/RC with an x0/zero-immediate operand are pure reads.
    function automatic logic csr_op_writes(input csr_op_e op, input logic rs1_zero);
        return (op == CSR_OP_RW) || (((op == CSR_OP_RS) || (op == CSR_OP_RC)) && !rs1_zero);
    endfunction

endpackage

// File: rtl/csr_machine_if.sv
// Retire-side CSR access / trap redirect bundle between the commit stage
// (master) and csr_machine (slave).
interface csr_machine_if #(
    parameter int unsigned XLEN = 64
);
    logic            inst_valid;
    logic [11:0]     csr_index;
    logic [1:0]      csr_op;
    logic [XLEN-1:0] csr_wdata;
    logic            csr_rs1_zero;
    logic [XLEN-1:0] inst_addr;
    logic            exc_valid;
    logic [3:0]      exc_cause;
    logic [XLEN-1:0] exc_tval;
    logic            inst_mret;
    logic [XLEN-1:0] csr_rdata;
    logic            trap_take;
    logic [XLEN-1:0] trap_pc;

    modport master (
        output inst_valid, csr_index, csr_op, csr_wdata, csr_rs1_zero, inst_addr,
               exc_valid, exc_cause, exc_tval, inst_mret,
        input  csr_rdata, trap_take, trap_pc
    );

    modport slave (
        input  inst_valid, csr_index, csr_op, csr_wdata, csr_rs1_zero, inst_addr,
               exc_valid, exc_cause, exc_tval, inst_mret,
        output csr_rdata, trap_take, trap_pc
    );
endinterface

// File: rtl/csr_machine_counter.sv
// XLEN-wide machine counter: inhibit gate, increment strobe, explicit write
// override and natural wrap to zero.
module csr_machine_counter #(
    parameter int unsigned XLEN = 64
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            inhibit,
    input  logic            inc,
    input  logic            wr_en,
    input  logic [XLEN-1:0] wr_data,
    output logic [XLEN-1:0] value
);
    localparam logic [XLEN-1:0] ONE = XLEN'(1);

    logic [XLEN-1:0] value_q, value_d;

    always_comb begin
        value_d = value_q;
        if (wr_en) begin
            value_d = wr_data;
        end else if (inc && !inhibit) begin
            value_d = value_q + ONE;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            value_q <= '0;
        end else begin
            value_q <= value_d;
        end
    end

    assign value = value_q;

endmodule

// File: rtl/csr_machine.sv
// Machine-mode CSR unit with trap entry/return, vectored mtvec and counters.
// Optional `CSR_DIFFTEST_EN exposes live CSR state and a counter-read skip flag.
module csr_machine
    import csr_machine_pkg::*;
#(
    parameter int unsigned XLEN    = 64,
    parameter int unsigned NUM_HPM = 2,
    parameter int unsigned HART_ID = 0
) (
    input  logic                                    clk,
    input  logic                                    rst,
    csr_machine_if.slave                            bus,
    input  logic                                    irq_meip,
    input  logic                                    irq_msip,
    input  logic                                    irq_mtip,
    input  logic [((NUM_HPM > 0) ? NUM_HPM : 1)-1:0] hpm_event,
    output logic                                    irq_pending
`ifdef CSR_DIFFTEST_EN
    ,
    output logic [XLEN-1:0]                         mstatus,
    output logic [XLEN-1:0]                         mtvec,
    output logic [XLEN-1:0]                         mepc,
    output logic [XLEN-1:0]                         mcause,
    output logic [XLEN-1:0]                         mtval,
    output logic [XLEN-1:0]                         mip,
    output logic [XLEN-1:0]                         mie,
    output logic [XLEN-1:0]                         mscratch,
    output logic                                    csr_skip
`endif
);
    localparam int unsigned     HPM_W       = (NUM_HPM > 0) ? NUM_HPM : 1;
    localparam logic [XLEN-1:0] MISA_VAL    = {((XLEN == 64) ? 2'b10 : 2'b01), {(XLEN-11){1'b0}}, 1'b1, 8'h00};
    localparam logic [XLEN-1:0] MIE_MASK    = XLEN'(12'h888);
    localparam logic [XLEN-1:0] CNTINH_MASK = XLEN'((((64'd1 << NUM_HPM) - 64'd1) << 3) | 64'd5);
    localparam logic [XLEN-1:0] ALIGN4_MASK = ~XLEN'(3);

    csr_op_e         op;
    logic            mstatus_mie_q, mstatus_mie_d;
    logic            mstatus_mpie_q, mstatus_mpie_d;
    logic [XLEN-1:0] mie_q, mie_d, mip_q, mip_d, mtvec_q, mtvec_d;
    logic [XLEN-1:0] mscratch_q, mscratch_d, mepc_q, mepc_d;
    logic [XLEN-1:0] mcause_q, mcause_d, mtval_q, mtval_d;
    logic [XLEN-1:0] mcountinhibit_q, mcountinhibit_d;

    logic [XLEN-1:0] mstatus_rd, mcycle_val, minstret_val, rdata, wval, pend;
    logic [XLEN-1:0] hpm_val [HPM_W];
    logic            csr_impl, hpm_hit, csr_write, illegal, exception, interrupt;
    logic            trap_entry, mret_take, csr_we, retire;
    logic            mcycle_we, minstret_we;
    logic [3:0]      trap_code, irq_code;

    assign op = csr_op_e'(bus.csr_op);

    always_comb begin
        mstatus_rd               = '0;
        mstatus_rd[12:11]        = 2'b11;
        mstatus_rd[MSTATUS_MPIE] = mstatus_mpie_q;
        mstatus_rd[MSTATUS_MIE]  = mstatus_mie_q;
    end

    // Read decode; unknown addresses clear csr_impl and become illegal.
    always_comb begin
        rdata    = '0;
        csr_impl = 1'b1;
        hpm_hit  = 1'b0;
        case (bus.csr_index)
            CSR_MSTATUS:       rdata = mstatus_rd;
            CSR_MISA:          rdata = MISA_VAL;
            CSR_MIE:           rdata = mie_q;
            CSR_MTVEC:         rdata = mtvec_q;
            CSR_MCOUNTINHIBIT: rdata = mcountinhibit_q;
            CSR_MSCRATCH:      rdata = mscratch_q;
            CSR_MEPC:          rdata = mepc_q;
            CSR_MCAUSE:        rdata = mcause_q;
            CSR_MTVAL:         rdata = mtval_q;
            CSR_MIP:           rdata = mip_q;
            CSR_MCYCLE:        rdata = mcycle_val;
            CSR_MINSTRET:      rdata = minstret_val;
            CSR_MVENDORID, CSR_MARCHID, CSR_MIMPID: rdata = '0;
            CSR_MHARTID:       rdata = XLEN'(HART_ID);
            default: begin
                csr_impl = 1'b0;
                for (int unsigned i = 0; i < NUM_HPM; i++) begin
                    if (bus.csr_index == CSR_MHPMCOUNTER3 + 12'(i)) begin
                        rdata    = hpm_val[i];
                        csr_impl = 1'b1;
                        hpm_hit  = 1'b1;
                    end
                end
            end
        endcase
    end

    always_comb begin
        csr_write = csr_op_writes(op, bus.csr_rs1_zero);
        illegal   = bus.inst_valid && (op != CSR_OP_NONE) &&
                    (!csr_impl || (csr_is_read_only(bus.csr_index) && csr_write));
        exception = bus.inst_valid && (bus.exc_valid || illegal);
        pend        = mip_q & mie_q;
        irq_pending = (|pend) && mstatus_mie_q;
        interrupt   = bus.inst_valid && !exception && irq_pending;
        if (pend[MIP_MEIP])      irq_code = IRQ_CODE_MEI;
        else if (pend[MIP_MSIP]) irq_code = IRQ_CODE_MSI;
        else                     irq_code = IRQ_CODE_MTI;
        trap_code   = exception ? (bus.exc_valid ? bus.exc_cause : CAUSE_ILLEGAL_INST) : irq_code;
        trap_entry  = exception || interrupt;
        mret_take   = bus.inst_valid && bus.inst_mret && !trap_entry;
        retire      = bus.inst_valid && !trap_entry;
        csr_we      = retire && !bus.inst_mret && csr_write;
        mcycle_we   = csr_we && (bus.csr_index == CSR_MCYCLE);
        minstret_we = csr_we && (bus.csr_index == CSR_MINSTRET);
        case (op)
            CSR_OP_RS: wval = rdata | bus.csr_wdata;
            CSR_OP_RC: wval = rdata & ~bus.csr_wdata;
            default:   wval = bus.csr_wdata;
        endcase
    end

    // Vector offset applies to interrupts only; exceptions always land on BASE.
    always_comb begin
        bus.csr_rdata = rdata;
        bus.trap_take = trap_entry || mret_take;
        bus.trap_pc   = '0;
        if (trap_entry) begin
            bus.trap_pc = mtvec_q & ALIGN4_MASK;
            if (mtvec_q[0] && interrupt) begin
                bus.trap_pc = (mtvec_q & ALIGN4_MASK) + {{(XLEN-6){1'b0}}, irq_code, 2'b00};
            end
        end else if (mret_take) begin
            bus.trap_pc = mepc_q;
        end
    end

    always_comb begin
        mstatus_mie_d   = mstatus_mie_q;
        mstatus_mpie_d  = mstatus_mpie_q;
        mie_d           = mie_q;
        mtvec_d         = mtvec_q;
        mscratch_d      = mscratch_q;
        mepc_d          = mepc_q;
        mcause_d        = mcause_q;
        mtval_d         = mtval_q;
        mcountinhibit_d = mcountinhibit_q;
        mip_d           = '0;
        mip_d[MIP_MEIP] = irq_meip;
        mip_d[MIP_MSIP] = irq_msip;
        mip_d[MIP_MTIP] = irq_mtip;
        if (trap_entry) begin
            mepc_d         = bus.inst_addr & ALIGN4_MASK;
            mcause_d       = {interrupt, {(XLEN-5){1'b0}}, trap_code};
            mtval_d        = (exception && bus.exc_valid) ? bus.exc_tval : '0;
            mstatus_mpie_d = mstatus_mie_q;
            mstatus_mie_d  = 1'b0;
        end else if (mret_take) begin
            mstatus_mie_d  = mstatus_mpie_q;
            mstatus_mpie_d = 1'b1;
        end else if (csr_we) begin
            case (bus.csr_index)
                CSR_MSTATUS: begin
                    mstatus_mie_d  = wval[MSTATUS_MIE];
                    mstatus_mpie_d = wval[MSTATUS_MPIE];
                end
                CSR_MIE:           mie_d           = wval & MIE_MASK;
                CSR_MTVEC:         mtvec_d         = {wval[XLEN-1:2], 1'b0, wval[0]};
                CSR_MSCRATCH:      mscratch_d      = wval;
                CSR_MEPC:          mepc_d          = wval & ALIGN4_MASK;
                CSR_MCAUSE:        mcause_d        = wval;
                CSR_MTVAL:         mtval_d         = wval;
                CSR_MCOUNTINHIBIT: mcountinhibit_d = wval & CNTINH_MASK;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            mstatus_mie_q   <= 1'b0;
            mstatus_mpie_q  <= 1'b0;
            mie_q           <= '0;
            mip_q           <= '0;
            mtvec_q         <= '0;
            mscratch_q      <= '0;
            mepc_q          <= '0;
            mcause_q        <= '0;
            mtval_q         <= '0;
            mcountinhibit_q <= '0;
        end else begin
            mstatus_mie_q   <= mstatus_mie_d;
            mstatus_mpie_q  <= mstatus_mpie_d;
            mie_q           <= mie_d;
            mip_q           <= mip_d;
            mtvec_q         <= mtvec_d;
            mscratch_q      <= mscratch_d;
            mepc_q          <= mepc_d;
            mcause_q        <= mcause_d;
            mtval_q         <= mtval_d;
            mcountinhibit_q <= mcountinhibit_d;
        end
    end

    csr_machine_counter #(.XLEN(XLEN)) u_mcycle (
        .clk     (clk),
        .rst     (rst),
        .inhibit (mcountinhibit_q[0]),
        .inc     (1'b1),
        .wr_en   (mcycle_we),
        .wr_data (wval),
        .value   (mcycle_val)
    );

    csr_machine_counter #(.XLEN(XLEN)) u_minstret (
        .clk     (clk),
        .rst     (rst),
        .inhibit (mcountinhibit_q[2]),
        .inc     (retire),
        .wr_en   (minstret_we),
        .wr_data (wval),
        .value   (minstret_val)
    );

    for (genvar i = 0; i < NUM_HPM; i++) begin : g_hpm
        logic we;
        always_comb we = csr_we && (bus.csr_index == CSR_MHPMCOUNTER3 + 12'(i));
        csr_machine_counter #(.XLEN(XLEN)) u_hpm (
            .clk     (clk),
            .rst     (rst),
            .inhibit (mcountinhibit_q[3+i]),
            .inc     (hpm_event[i]),
            .wr_en   (we),
            .wr_data (wval),
            .value   (hpm_val[i])
        );
    end

`ifdef CSR_DIFFTEST_EN
    always_comb begin
        mstatus  = mstatus_rd;
        mtvec    = mtvec_q;
        mepc     = mepc_q;
        mcause   = mcause_q;
        mtval    = mtval_q;
        mip      = mip_q;
        mie      = mie_q;
        mscratch = mscratch_q;
        csr_skip = (bus.csr_index == CSR_MCYCLE) || (bus.csr_index == CSR_MINSTRET) || hpm_hit;
    end
`endif

endmodule

// File: tb/tb_csr_machine.sv
// Directed self-checking bench for csr_machine (XLEN=64, NUM_HPM=2, HART_ID=3).
module tb_csr_machine;
    localparam int unsigned XLEN    = 64;
    localparam int unsigned NUM_HPM = 2;
    localparam int unsigned HART_ID = 3;
    localparam logic [1:0]  OP_NONE = 2'b00;
    localparam logic [1:0]  OP_RW   = 2'b01;
    localparam logic [1:0]  OP_RS   = 2'b10;
    localparam logic [1:0]  OP_RC   = 2'b11;

    logic               clk = 1'b0;
    logic               rst;
    logic               irq_meip, irq_msip, irq_mtip;
    logic [NUM_HPM-1:0] hpm_event;
    logic               irq_pending;
    int unsigned        checks   = 0;
    int unsigned        failures = 0;

    csr_machine_if #(.XLEN(XLEN)) bus ();

`ifdef CSR_DIFFTEST_EN
    logic [XLEN-1:0] dt_mstatus, dt_mtvec, dt_mepc, dt_mcause, dt_mtval, dt_mip, dt_mie, dt_mscratch;
    logic            dt_skip;
`endif

    csr_machine #(.XLEN(XLEN), .NUM_HPM(NUM_HPM), .HART_ID(HART_ID)) dut (
        .clk         (clk),
        .rst         (rst),
        .bus         (bus),
        .irq_meip    (irq_meip),
        .irq_msip    (irq_msip),
        .irq_mtip    (irq_mtip),
        .hpm_event   (hpm_event),
        .irq_pending (irq_pending)
`ifdef CSR_DIFFTEST_EN
        ,
        .mstatus     (dt_mstatus),
        .mtvec       (dt_mtvec),
        .mepc        (dt_mepc),
        .mcause      (dt_mcause),
        .mtval       (dt_mtval),
        .mip         (dt_mip),
        .mie         (dt_mie),
        .mscratch    (dt_mscratch),
        .csr_skip    (dt_skip)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%016h exp=0x%016h", tag, got, exp);
        end
    endtask

    // One retiring-instruction cycle; outputs are settled 1ns after the negedge.
    task automatic step(input logic [11:0] idx, input logic [1:0] op, input logic [63:0] wdata,
                        input logic rs1z, input logic [63:0] pc, input logic exc,
                        input logic [3:0] cause, input logic [63:0] tval, input logic mret);
        @(negedge clk);
        bus.inst_valid   = 1'b1;
        bus.csr_index    = idx;
        bus.csr_op       = op;
        bus.csr_wdata    = wdata;
        bus.csr_rs1_zero = rs1z;
        bus.inst_addr    = pc;
        bus.exc_valid    = exc;
        bus.exc_cause    = cause;
        bus.exc_tval     = tval;
        bus.inst_mret    = mret;
        #1;
    endtask

    task automatic rd(input logic [11:0] idx);
        step(idx, OP_RS, 64'h0, 1'b1, 64'h100, 1'b0, 4'd0, 64'h0, 1'b0);
    endtask

    task automatic wr(input logic [11:0] idx, input logic [1:0] op, input logic [63:0] data);
        step(idx, op, data, 1'b0, 64'h104, 1'b0, 4'd0, 64'h0, 1'b0);
    endtask

    task automatic idle(input int unsigned n);
        for (int unsigned k = 0; k < n; k++) begin
            @(negedge clk);
            bus.inst_valid = 1'b0;
            bus.csr_op     = OP_NONE;
            bus.exc_valid  = 1'b0;
            bus.inst_mret  = 1'b0;
        end
        #1;
    endtask

    initial begin
        rst = 1'b1;
        irq_meip = 1'b0; irq_msip = 1'b0; irq_mtip = 1'b0;
        hpm_event = '0;
        bus.inst_valid = 1'b0; bus.csr_index = '0; bus.csr_op = OP_NONE;
        bus.csr_wdata = '0; bus.csr_rs1_zero = 1'b0; bus.inst_addr = '0;
        bus.exc_valid = 1'b0; bus.exc_cause = '0; bus.exc_tval = '0; bus.inst_mret = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        #1;
        check("rst_irq_pending", {63'b0, irq_pending}, 64'h0);
        check("rst_trap_take", {63'b0, bus.trap_take}, 64'h0);

        rd(12'h300); check("rst_mstatus", bus.csr_rdata, 64'h1800);
        check("read_no_trap", {63'b0, bus.trap_take}, 64'h0);
        rd(12'hF14); check("mhartid", bus.csr_rdata, 64'h3);
        rd(12'h301); check("misa", bus.csr_rdata, 64'h8000_0000_0000_0100);
        rd(12'h342); check("rst_mcause", bus.csr_rdata, 64'h0);

        wr(12'h305, OP_RW, 64'h8000_1003);
        rd(12'h305); check("mtvec_bit1_forced", bus.csr_rdata, 64'h8000_1001);
        wr(12'h340, OP_RW, 64'hFF);
        wr(12'h340, OP_RC, 64'h0F);
        wr(12'h340, OP_RS, 64'h100);
        rd(12'h340); check("mscratch_rs_rc", bus.csr_rdata, 64'h1F0);

        // Timer interrupt, vectored.
        wr(12'h304, OP_RW, 64'h80);
        irq_mtip = 1'b1;
        wr(12'h300, OP_RW, 64'h8);
        check("mstatus_old_on_wr", bus.csr_rdata, 64'h1800);
        check("no_irq_before_mie", {63'b0, bus.trap_take}, 64'h0);
        step(12'h340, OP_RS, 64'h0, 1'b1, 64'h1006, 1'b0, 4'd0, 64'h0, 1'b0);
        check("mti_irq_pending", {63'b0, irq_pending}, 64'h1);
        check("mti_trap_take", {63'b0, bus.trap_take}, 64'h1);
        check("mti_trap_pc", bus.trap_pc, 64'h8000_101C);
        rd(12'h342); check("mti_mcause", bus.csr_rdata, 64'h8000_0000_0000_0007);
        rd(12'h300); check("mti_mstatus", bus.csr_rdata, 64'h1880);
        rd(12'h341); check("mti_mepc", bus.csr_rdata, 64'h1004);
        rd(12'h343); check("mti_mtval", bus.csr_rdata, 64'h0);
        irq_mtip = 1'b0;
        idle(1);
        step(12'h000, OP_NONE, 64'h0, 1'b0, 64'h1010, 1'b0, 4'd0, 64'h0, 1'b1);
        check("mret_take", {63'b0, bus.trap_take}, 64'h1);
        check("mret_pc", bus.trap_pc, 64'h1004);
        rd(12'h300); check("mret_mstatus", bus.csr_rdata, 64'h1888);

        // MEI beats MTI, then MSI beats MTI.
        wr(12'h304, OP_RW, 64'hFFFF);
        rd(12'h304); check("mie_mask", bus.csr_rdata, 64'h888);
        irq_meip = 1'b1; irq_mtip = 1'b1;
        idle(1);
        check("idle_irq_pending", {63'b0, irq_pending}, 64'h1);
        check("idle_no_trap", {63'b0, bus.trap_take}, 64'h0);
        step(12'h000, OP_NONE, 64'h0, 1'b0, 64'h2000, 1'b0, 4'd0, 64'h0, 1'b0);
        check("mei_trap_pc", bus.trap_pc, 64'h8000_102C);
        irq_meip = 1'b0; irq_msip = 1'b1;
        rd(12'h342); check("mei_mcause", bus.csr_rdata, 64'h8000_0000_0000_000B);
        step(12'h000, OP_NONE, 64'h0, 1'b0, 64'h2010, 1'b0, 4'd0, 64'h0, 1'b1);
        check("mret2_pc", bus.trap_pc, 64'h2000);
        step(12'h000, OP_NONE, 64'h0, 1'b0, 64'h2100, 1'b0, 4'd0, 64'h0, 1'b0);
        check("msi_trap_pc", bus.trap_pc, 64'h8000_100C);
        irq_msip = 1'b0; irq_mtip = 1'b0;
        idle(1);
        rd(12'h342); check("msi_mcause", bus.csr_rdata, 64'h8000_0000_0000_0003);
        rd(12'h300); check("msi_mstatus", bus.csr_rdata, 64'h1880);

        // Exceptions are not vectored; upstream exception beats illegal CSR.
        step(12'h000, OP_NONE, 64'h0, 1'b0, 64'h3003, 1'b1, 4'd5, 64'hDEAD, 1'b0);
        check("exc_take", {63'b0, bus.trap_take}, 64'h1);
        check("exc_pc", bus.trap_pc, 64'h8000_1000);
        rd(12'h342); check("exc_mcause", bus.csr_rdata, 64'h5);
        rd(12'h343); check("exc_mtval", bus.csr_rdata, 64'hDEAD);
        rd(12'h341); check("exc_mepc", bus.csr_rdata, 64'h3000);
        step(12'hF11, OP_RW, 64'h1, 1'b0, 64'h3100, 1'b1, 4'd4, 64'h77, 1'b0);
        rd(12'h342); check("exc_over_illegal_cause", bus.csr_rdata, 64'h4);
        rd(12'h343); check("exc_over_illegal_tval", bus.csr_rdata, 64'h77);

        wr(12'hB03, OP_RW, 64'h55);
        check("hpm_write_legal", {63'b0, bus.trap_take}, 64'h0);
        rd(12'hB03); check("hpm3_written", bus.csr_rdata, 64'h55);
        step(12'hF11, OP_RW, 64'h1, 1'b0, 64'h4002, 1'b0, 4'd0, 64'h0, 1'b0);
        check("ro_write_take", {63'b0, bus.trap_take}, 64'h1);
        check("ro_write_pc", bus.trap_pc, 64'h8000_1000);
        rd(12'h342); check("illegal_mcause", bus.csr_rdata, 64'h2);
        rd(12'h341); check("illegal_mepc", bus.csr_rdata, 64'h4000);
        rd(12'h343); check("illegal_mtval", bus.csr_rdata, 64'h0);
        rd(12'hF11); check("mvendorid_unchanged", bus.csr_rdata, 64'h0);
        rd(12'h7C0); check("unimpl_take", {63'b0, bus.trap_take}, 64'h1);

        // mcycle inhibit, write override, wrap.
        wr(12'h320, OP_RW, 64'h1);
        wr(12'hB00, OP_RW, 64'h100);
        idle(10);
        rd(12'hB00); check("mcycle_inhibited", bus.csr_rdata, 64'h100);
        wr(12'hB00, OP_RW, 64'hFFFF_FFFF_FFFF_FFFF);
        check("mcycle_old_on_wr", bus.csr_rdata, 64'h100);
        wr(12'h320, OP_RW, 64'h0);
        check("mcountinhibit_rd", bus.csr_rdata, 64'h1);
        rd(12'hB00); check("mcycle_max", bus.csr_rdata, 64'hFFFF_FFFF_FFFF_FFFF);
        rd(12'hB00); check("mcycle_wrap", bus.csr_rdata, 64'h0);

        // minstret inhibit and retire counting.
        wr(12'h320, OP_RW, 64'h4);
        wr(12'hB02, OP_RW, 64'h7);
        rd(12'h340);
        rd(12'h340);
        wr(12'h320, OP_RW, 64'h0);
        rd(12'hB02); check("minstret_inhibited", bus.csr_rdata, 64'h7);
        rd(12'hB02); check("minstret_inc", bus.csr_rdata, 64'h8);

        idle(1);
        hpm_event = 2'b10;
        idle(3);
        hpm_event = 2'b00;
        rd(12'hB04); check("hpm4_events", bus.csr_rdata, 64'h3);
        rd(12'hB03); check("hpm3_no_events", bus.csr_rdata, 64'h55);

        // Reset in the same cycle as a trapping instruction.
        @(negedge clk);
        rst = 1'b1;
        bus.inst_valid = 1'b1; bus.csr_op = OP_NONE; bus.inst_addr = 64'h5000;
        bus.exc_valid = 1'b1; bus.exc_cause = 4'd5; bus.exc_tval = 64'h99;
        @(negedge clk);
        rst = 1'b0;
        bus.inst_valid = 1'b0; bus.exc_valid = 1'b0;
        rd(12'h342); check("rst_trap_mcause", bus.csr_rdata, 64'h0);
        rd(12'h300); check("rst_trap_mstatus", bus.csr_rdata, 64'h1800);
        rd(12'h305); check("rst_trap_mtvec", bus.csr_rdata, 64'h0);
        idle(1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
